// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared N_REQ:1 mux.
// Produces a registered one-hot grant, the matching select and sel_valid, with a hold limit per owner.
module mux_rr_arbiter #(
   parameter int N_REQ    = 8,
   parameter int SEL_W    = 3,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [SEL_W-1:0] select,
   output logic             sel_valid
);

   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   // Handshake: req[i] is a level request, and it stays high for as long as the requester wants the mux.
   // grant[i] is the registered acknowledgement, and the mux data for input i is valid while
   // grant[i] and sel_valid are high. No other flow control is involved.

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t            state;
   state_t            state_d;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_cnt_d;
   logic [SEL_W-1:0]  last;
   logic [SEL_W-1:0]  last_d;
   logic [N_REQ-1:0]  grant_d;
   logic [SEL_W-1:0]  select_d;

   logic [N_REQ-1:0]  others;
   logic              owner_req;
   logic              hold_done;
   logic [N_REQ-1:0]  search_mask;
   logic              win_found;
   logic [SEL_W-1:0]  win_idx;
   logic              take_new;

   assign others    = req & ~grant;
   assign owner_req = |(req & grant);
   assign hold_done = (hold_cnt == HOLD_LAST);

   // While a grant is held, the current owner is left out of the search. It is then only found again
   // through the "no other request" paths, which keep it without a search.
   assign search_mask = (state == IDLE) ? req : others;

   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(last) + 1 + k) % N_REQ;
         if (!win_found && search_mask[idx]) begin
            win_found = 1'b1;
            win_idx   = SEL_W'(idx);
         end
      end
   end

   always_comb begin
      take_new = 1'b0;
      if (enable && win_found) begin
         if (state == IDLE)
            take_new = 1'b1;
         else if (!owner_req || hold_done)
            take_new = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (enable && (|req))
               state_d = GRANT;
         end
         GRANT: begin
            if (!owner_req && !take_new)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: next values of the registered grant, select, last and hold counter
   always_comb begin
      grant_d    = grant;
      select_d   = select;
      last_d     = last;
      hold_cnt_d = hold_cnt;
      if (take_new) begin
         grant_d    = '0;
         grant_d[win_idx] = 1'b1;
         select_d   = win_idx;
         last_d     = win_idx;
         hold_cnt_d = '0;
      end else if (state == GRANT) begin
         if (!owner_req) begin
            grant_d    = '0;
            hold_cnt_d = '0;
         end else if (hold_done) begin
            // With rivals waiting but enable low, the counter stays saturated.
            // Rotation then happens at the first edge after enable returns.
            hold_cnt_d = (|others) ? hold_cnt : '0;
         end else begin
            hold_cnt_d = hold_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant    <= '0;
         select   <= '0;
         last     <= SEL_W'(N_REQ - 1);
         hold_cnt <= '0;
      end else begin
         grant    <= grant_d;
         select   <= select_d;
         last     <= last_d;
         hold_cnt <= hold_cnt_d;
      end
   end

   assign sel_valid = |grant;

   a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_select_match : assert property (@(posedge clk) disable iff (rst) sel_valid |-> grant[select]);
   a_state_match  : assert property (@(posedge clk) disable iff (rst) (state == GRANT) == sel_valid);

endmodule
